// File: rtl/mxint_linear_arbiter.sv
// Frame-granular round-robin arbiter sharing one mxint_linear between two requesters.
// Grants whole input tensors, records owners in a tag FIFO and routes results back by tag.
module mxint_linear_arbiter #(
    parameter int PRECISION_0     = 16,
    parameter int PRECISION_1     = 3,
    parameter int IN_NUM          = 16,
    parameter int IN_BEATS        = 25,
    parameter int OUT_PRECISION_0 = 16,
    parameter int OUT_PRECISION_1 = 3,
    parameter int OUT_NUM         = 16,
    parameter int OUT_BEATS       = 25,
    parameter int TAG_DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PRECISION_0-1:0]     mdata_in_0 [IN_NUM-1:0],
    input  logic [PRECISION_1-1:0]     edata_in_0,
    input  logic                       data_in_0_valid,
    output logic                       data_in_0_ready,
    input  logic [PRECISION_0-1:0]     mdata_in_1 [IN_NUM-1:0],
    input  logic [PRECISION_1-1:0]     edata_in_1,
    input  logic                       data_in_1_valid,
    output logic                       data_in_1_ready,
    output logic [PRECISION_0-1:0]     mdata_out [IN_NUM-1:0],
    output logic [PRECISION_1-1:0]     edata_out,
    output logic                       data_out_valid,
    input  logic                       data_out_ready,
    input  logic [OUT_PRECISION_0-1:0] mresult_in [OUT_NUM-1:0],
    input  logic [OUT_PRECISION_1-1:0] eresult_in,
    input  logic                       result_in_valid,
    output logic                       result_in_ready,
    output logic [OUT_PRECISION_0-1:0] mresult_out_0 [OUT_NUM-1:0],
    output logic [OUT_PRECISION_1-1:0] eresult_out_0,
    output logic                       result_out_0_valid,
    input  logic                       result_out_0_ready,
    output logic [OUT_PRECISION_0-1:0] mresult_out_1 [OUT_NUM-1:0],
    output logic [OUT_PRECISION_1-1:0] eresult_out_1,
    output logic                       result_out_1_valid,
    input  logic                       result_out_1_ready,
    output logic                       busy,
    output logic                       grant,
    output logic [$clog2(TAG_DEPTH):0] outstanding
);

    localparam int PTR_W     = $clog2(TAG_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int IN_CNT_W  = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
    localparam int OUT_CNT_W = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_q, state_d;
    logic                 grant_q, grant_d;
    logic                 last_grant_q, last_grant_d;
    logic [IN_CNT_W-1:0]  in_cnt_q, in_cnt_d;
    logic [OUT_CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [TAG_DEPTH-1:0] tag_q, tag_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic tag_full, tag_empty, tag_head;
    logic push, pop, winner, sel_valid, in_hs, res_hs;

    assign tag_full    = (count_q == CNT_W'(TAG_DEPTH));
    assign tag_empty   = (count_q == '0);
    assign tag_head    = tag_q[rd_ptr_q];
    assign busy        = (state_q == BUSY);
    assign grant       = grant_q;
    assign outstanding = count_q;

    // Input FSM: a grant lasts a whole tensor; the owner tag is pushed at grant time.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_grant_d    = last_grant_q;
        in_cnt_d        = in_cnt_q;
        push            = 1'b0;
        winner          = 1'b0;
        in_hs           = 1'b0;
        data_out_valid  = 1'b0;
        data_in_0_ready = 1'b0;
        data_in_1_ready = 1'b0;
        sel_valid       = grant_q ? data_in_1_valid : data_in_0_valid;
        case (state_q)
            IDLE: begin
                if (!tag_full && (data_in_0_valid || data_in_1_valid)) begin
                    winner   = (data_in_0_valid && data_in_1_valid) ? !last_grant_q : data_in_1_valid;
                    grant_d  = winner;
                    push     = 1'b1;
                    in_cnt_d = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                data_out_valid  = sel_valid;
                data_in_0_ready = !grant_q && data_out_ready;
                data_in_1_ready = grant_q && data_out_ready;
                in_hs           = sel_valid && data_out_ready;
                if (in_hs) begin
                    if (in_cnt_q == IN_CNT_W'(IN_BEATS - 1)) begin
                        in_cnt_d     = '0;
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < IN_NUM; i++) begin
            mdata_out[i] = grant_q ? mdata_in_1[i] : mdata_in_0[i];
        end
        edata_out = grant_q ? edata_in_1 : edata_in_0;
    end

    // Result router: only the FIFO head owner sees valid; payload is broadcast.
    always_comb begin
        result_in_ready    = 1'b0;
        result_out_0_valid = 1'b0;
        result_out_1_valid = 1'b0;
        if (!tag_empty) begin
            result_in_ready    = tag_head ? result_out_1_ready : result_out_0_ready;
            result_out_0_valid = !tag_head && result_in_valid;
            result_out_1_valid = tag_head && result_in_valid;
        end
        for (int unsigned i = 0; i < OUT_NUM; i++) begin
            mresult_out_0[i] = mresult_in[i];
            mresult_out_1[i] = mresult_in[i];
        end
        eresult_out_0 = eresult_in;
        eresult_out_1 = eresult_in;
    end

    always_comb begin
        res_hs    = result_in_valid && result_in_ready;
        pop       = 1'b0;
        out_cnt_d = out_cnt_q;
        if (res_hs) begin
            if (out_cnt_q == OUT_CNT_W'(OUT_BEATS - 1)) begin
                pop       = 1'b1;
                out_cnt_d = '0;
            end else begin
                out_cnt_d = out_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            tag_d[wr_ptr_q] = winner;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            tag_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

endmodule
